// File: rtl/acc_pkg.sv
// Shared defaults, datapath widths and FSM encoding for the accumulator job scheduler.
package acc_pkg;

    localparam int IFM_BIT_DEF = 8;
    localparam int W_BIT_DEF   = 8;
    localparam int K_DEF       = 3;
    localparam int IN_CH_DEF   = 512;
    localparam int MAX_DIM_DEF = 64;
    localparam int TIMEOUT_DEF = 100;

    function automatic int acc_sum_width(input int ifm_bit, input int w_bit,
                                         input int k, input int in_ch);
        return ifm_bit + w_bit + $clog2(k * k * in_ch);
    endfunction

    localparam int BIT_PE  = IFM_BIT_DEF + W_BIT_DEF + $clog2(K_DEF * IN_CH_DEF);
    localparam int BIT_ACC = acc_sum_width(IFM_BIT_DEF, W_BIT_DEF, K_DEF, IN_CH_DEF);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PE_RUN    = 3'd1,
        ACC_ISSUE = 3'd2,
        ACC_WAIT  = 3'd3,
        DRAIN     = 3'd4,
        FIN       = 3'd5
    } acc_state_e;

endpackage

// File: rtl/acc_out_buffer.sv
// One-entry valid/ready output register holding an accumulator sum and its last-pixel flag.
module acc_out_buffer
    import acc_pkg::*;
#(
    parameter int W = BIT_ACC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_last,
    input  logic [W-1:0] i_data,
    input  logic         i_flush,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_free
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end

    // Free when empty or when the current entry leaves this cycle.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/acc_scheduler.sv
// Job-level scheduler: walks the out_h x out_w pixel grid, sequencing the PE array and
// accumulator per pixel and buffering each sum behind a valid/ready handshake.
//
// state     | meaning
// IDLE      | waiting for start, cfg latched on accept
// PE_RUN    | PE array computing the current pixel, watchdog running
// ACC_ISSUE | PE result ready, waiting for a free output buffer to pulse the accumulator
// ACC_WAIT  | waiting for the accumulator sum, watchdog running
// DRAIN     | final sum buffered, waiting for downstream to take it
// FIN       | one-cycle done pulse, then back to IDLE
module acc_scheduler
    import acc_pkg::*;
#(
    parameter int IFM_BIT  = IFM_BIT_DEF,
    parameter int W_BIT    = W_BIT_DEF,
    parameter int K        = K_DEF,
    parameter int IN_CH    = IN_CH_DEF,
    parameter int MAX_DIM  = MAX_DIM_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    localparam int ACC_W   = acc_sum_width(IFM_BIT, W_BIT, K, IN_CH),
    localparam int DIM_W   = $clog2(MAX_DIM + 1),
    localparam int POS_W   = $clog2(MAX_DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_out_w,
    input  logic [DIM_W-1:0] cfg_out_h,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             pe_start,
    output logic [POS_W-1:0] pe_row,
    output logic [POS_W-1:0] pe_col,
    input  logic             pe_done,
    output logic             acc_in_valid,
    input  logic             acc_out_valid,
    input  logic [ACC_W-1:0] acc_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);

    localparam int               WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [DIM_W-1:0] r_cfg_w;
    logic [DIM_W-1:0] r_cfg_h;
    logic [POS_W-1:0] r_row;
    logic [POS_W-1:0] r_col;
    logic [WD_W-1:0]  r_wdog;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_pe_start;

    logic w_accept;
    logic w_pe_kick;
    logic w_wd_load;
    logic w_timeout;
    logic w_capture;
    logic w_acc_in_valid;
    logic w_free;
    logic w_col_last;
    logic w_last_px;
    logic w_wd_expire;
    logic w_wd_run;

    assign w_col_last  = (DIM_W'(r_col) == (r_cfg_w - DIM_ONE));
    assign w_last_px   = w_col_last && (DIM_W'(r_row) == (r_cfg_h - DIM_ONE));
    assign w_wd_expire = (r_wdog == '0);
    assign w_wd_run    = (r_state == PE_RUN) || (r_state == ACC_WAIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_pe_kick      = 1'b0;
        w_wd_load      = 1'b0;
        w_timeout      = 1'b0;
        w_capture      = 1'b0;
        w_acc_in_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if ((cfg_out_w == '0) || (cfg_out_h == '0)) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = PE_RUN;
                        w_pe_kick   = 1'b1;
                        w_wd_load   = 1'b1;
                    end
                end
            end
            PE_RUN: begin
                if (pe_done) begin
                    w_state_nxt = ACC_ISSUE;
                end else if (w_wd_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = FIN;
                end
            end
            ACC_ISSUE: begin
                if (w_free) begin
                    w_acc_in_valid = 1'b1;
                    w_wd_load      = 1'b1;
                    w_state_nxt    = ACC_WAIT;
                end
            end
            ACC_WAIT: begin
                if (acc_out_valid) begin
                    w_capture = 1'b1;
                    if (w_last_px) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = PE_RUN;
                        w_pe_kick   = 1'b1;
                        w_wd_load   = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = FIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cfg_w    <= '0;
            r_cfg_h    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_wdog     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pe_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pe_start <= w_pe_kick;
            r_done     <= (w_state_nxt == FIN);

            if (w_accept) begin
                r_cfg_w <= cfg_out_w;
                r_cfg_h <= cfg_out_h;
                r_err   <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state == FIN) begin
                r_busy <= 1'b0;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_wd_load) begin
                r_wdog <= WD_LOAD;
            end else if (w_wd_run && !w_wd_expire) begin
                r_wdog <= r_wdog - WD_ONE;
            end

            // Pixel position advances on each captured sum; it rests at 0 after the last one.
            if (w_accept || (w_capture && w_last_px)) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_capture) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + POS_ONE;
                end else begin
                    r_col <= r_col + POS_ONE;
                end
            end
        end
    end

    acc_out_buffer #(
        .W (ACC_W)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_capture),
        .i_last  (w_last_px),
        .i_data  (acc_result),
        .i_flush (w_timeout),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_free  (w_free)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign err_timeout  = r_err;
    assign pe_start     = r_pe_start;
    assign pe_row       = r_row;
    assign pe_col       = r_col;
    assign acc_in_valid = w_acc_in_valid;

endmodule

// File: tb/tb_acc_scheduler.sv
// Directed bench for acc_scheduler: a PE/accumulator responder plus logs checked against hand-timed expectations.
module tb_acc_scheduler;

    localparam int ACC_W = 29;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       cfg_out_w = '0;
    logic [6:0]       cfg_out_h = '0;
    logic             busy, done, err_timeout, pe_start;
    logic [5:0]       pe_row, pe_col;
    logic             pe_done = 1'b0;
    logic             acc_in_valid;
    logic             acc_out_valid = 1'b0;
    logic [ACC_W-1:0] acc_result = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic             out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int               pe_lat   = 2;
    bit               acc_en   = 1'b1;
    int               hold_len = 0;
    int               hold_req = 0;
    logic [ACC_W-1:0] res_tab [8];

    int               pe_cnt = 0, acc_cnt = 0, hold_cnt = 0, hold_ack = 0, job_idx = 0;
    int               hold_bad = 0, ov_total = 0, err_rise = -1;
    bit               prev_held = 1'b0, err_prev = 1'b0;
    logic [ACC_W-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    logic [11:0]      pe_log[$];
    int               pe_cyc_log[$];
    int               acc_iv_log[$];
    logic [ACC_W:0]   hs_log[$];
    int               hs_cyc_log[$];
    int               done_log[$];

    acc_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_out_w     (cfg_out_w),
        .cfg_out_h     (cfg_out_h),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .pe_start      (pe_start),
        .pe_row        (pe_row),
        .pe_col        (pe_col),
        .pe_done       (pe_done),
        .acc_in_valid  (acc_in_valid),
        .acc_out_valid (acc_out_valid),
        .acc_result    (acc_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder and logger: decides out_ready at the falling edge, then samples and answers 1 unit later.
    always begin
        @(negedge clk);
        if (hold_req != hold_ack && out_valid) begin
            hold_cnt = hold_len;
            hold_ack = hold_req;
        end
        out_ready = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
        #1;
        if (!rst_n) begin
            pe_cnt        = 0;
            acc_cnt       = 0;
            pe_done       = 1'b0;
            acc_out_valid = 1'b0;
            prev_held     = 1'b0;
            err_prev      = 1'b0;
        end else begin
            if (prev_held && (!out_valid || out_data != prev_data || out_last != prev_last)) hold_bad++;
            prev_held = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (start && !busy) job_idx = 0;
            if (pe_start) begin
                pe_log.push_back({pe_row, pe_col});
                pe_cyc_log.push_back(cyc);
            end
            pe_done = 1'b0;
            if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0) pe_done = 1'b1;
            end
            if (pe_start) begin
                if (pe_lat == 0) pe_done = 1'b1;
                else pe_cnt = pe_lat;
            end
            acc_out_valid = 1'b0;
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) begin
                    acc_out_valid = 1'b1;
                    acc_result    = (job_idx < 8) ? res_tab[job_idx] : '0;
                    job_idx++;
                end
            end
            if (acc_in_valid) begin
                acc_iv_log.push_back(cyc);
                if (acc_en) acc_cnt = 1;
            end
            if (out_valid && out_ready) begin
                hs_log.push_back({out_last, out_data});
                hs_cyc_log.push_back(cyc);
            end
            if (out_valid) ov_total++;
            if (done) done_log.push_back(cyc);
            if (err_timeout && !err_prev) err_rise = cyc;
            err_prev = err_timeout;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input int w, input int h, output int s);
        @(negedge clk);
        cfg_out_w = 7'(w);
        cfg_out_h = 7'(h);
        start     = 1'b1;
        s         = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        for (int k = 0; k < budget && done_log.size() <= base; k++) @(negedge clk);
        check_val(tag, 64'(done_log.size() > base), 1);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int s, b_pe, b_hs, b_iv, b_done, b_bad, ov0;
        logic [11:0]    exp_pix [4];
        logic [ACC_W:0] exp_hs  [4];
        exp_pix = '{12'h000, 12'h001, 12'h040, 12'h041};
        exp_hs  = '{{1'b0, 29'd10}, {1'b0, 29'd20}, {1'b0, 29'd30}, {1'b1, 29'd40}};
        res_tab = '{29'd10, 29'd20, 29'd30, 29'd40, 29'd0, 29'd0, 29'd0, 29'd0};

        // Reset values
        step(2);
        check_val("rst_ctrl", {busy, done, err_timeout, pe_start, acc_in_valid, out_valid, out_last}, 0);
        check_val("rst_pos", {pe_row, pe_col}, 0);
        check_val("rst_data", out_data, 0);
        rst_n = 1'b1;
        step(2);

        // 2x2, free-flowing downstream
        b_pe = pe_log.size(); b_hs = hs_log.size(); b_iv = acc_iv_log.size(); b_done = done_log.size();
        launch(2, 2, s);
        wait_done(b_done, 200, "t1_done_seen");
        check_val("t1_pe_first_cyc", pe_cyc_log[b_pe], s + 1);
        for (int i = 0; i < 4; i++) check_val($sformatf("t1_pix%0d", i), pe_log[b_pe + i], exp_pix[i]);
        for (int i = 0; i < 4; i++) check_val($sformatf("t1_beat%0d", i), hs_log[b_hs + i], exp_hs[i]);
        check_val("t1_acc_iv_cyc", acc_iv_log[b_iv], s + 4);
        check_val("t1_first_hs_cyc", hs_cyc_log[b_hs], s + 6);
        check_val("t1_last_hs_cyc", hs_cyc_log[b_hs + 3], s + 21);
        check_val("t1_done_cyc", done_log[b_done], s + 22);
        check_val("t1_done_count", done_log.size() - b_done, 1);
        check_val("t1_busy_after", busy, 0);

        // Same job, downstream stalls 20 cycles on the first beat
        b_pe = pe_log.size(); b_hs = hs_log.size(); b_iv = acc_iv_log.size(); b_done = done_log.size();
        b_bad = hold_bad;
        hold_len = 20;
        hold_req++;
        launch(2, 2, s);
        wait_done(b_done, 300, "t2_done_seen");
        check_val("t2_first_hs_cyc", hs_cyc_log[b_hs], s + 26);
        check_val("t2_second_acc_iv_cyc", acc_iv_log[b_iv + 1], s + 26);
        check_val("t2_pe2_cyc", pe_cyc_log[b_pe + 1], s + 6);
        check_val("t2_hold_stable", hold_bad - b_bad, 0);
        for (int i = 0; i < 4; i++) check_val($sformatf("t2_beat%0d", i), hs_log[b_hs + i], exp_hs[i]);

        // 1x1, accumulator never answers -> watchdog
        b_done = done_log.size(); ov0 = ov_total;
        acc_en = 1'b0;
        launch(1, 1, s);
        wait_done(b_done, 300, "t3_done_seen");
        check_val("t3_done_cyc", done_log[b_done], s + 105);
        check_val("t3_err_rise_cyc", err_rise, s + 105);
        check_val("t3_no_out_valid", ov_total - ov0, 0);
        step(3);
        check_val("t3_err_sticky", err_timeout, 1);
        acc_en = 1'b1;
        res_tab[0] = 29'd55;
        b_done = done_log.size(); b_hs = hs_log.size();
        launch(1, 1, s);
        check_val("t3_err_cleared", err_timeout, 0);
        wait_done(b_done, 200, "t3b_done_seen");
        check_val("t3b_beat", hs_log[b_hs], {1'b1, 29'd55});

        // start while busy (5x5) is ignored
        res_tab = '{29'd10, 29'd20, 29'd30, 29'd40, 29'd0, 29'd0, 29'd0, 29'd0};
        b_pe = pe_log.size(); b_hs = hs_log.size(); b_done = done_log.size();
        launch(2, 2, s);
        @(negedge clk);
        cfg_out_w = 7'd5; cfg_out_h = 7'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(b_done, 300, "t4_done_seen");
        step(10);
        check_val("t4_pe_count", pe_log.size() - b_pe, 4);
        check_val("t4_hs_count", hs_log.size() - b_hs, 4);
        check_val("t4_done_count", done_log.size() - b_done, 1);
        check_val("t4_done_cyc", done_log[b_done], s + 22);

        // zero width: straight to FIN
        b_pe = pe_log.size(); b_done = done_log.size(); ov0 = ov_total;
        launch(0, 3, s);
        step(5);
        check_val("t5_done_cyc", done_log[b_done], s + 1);
        check_val("t5_no_pe_start", pe_log.size() - b_pe, 0);
        check_val("t5_no_out_valid", ov_total - ov0, 0);
        check_val("t5_busy_after", busy, 0);

        // reset while waiting on the accumulator for pixel (0,1)
        b_done = done_log.size();
        launch(2, 2, s);
        step(6);
        acc_en = 1'b0;
        step(8);
        check_val("t6_pre_col", pe_col, 1);
        check_val("t6_pre_data", out_data, 10);
        check_val("t6_pre_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check_val("t6_rst_ctrl", {busy, done, err_timeout, pe_start, acc_in_valid, out_valid, out_last}, 0);
        check_val("t6_rst_pos", {pe_row, pe_col}, 0);
        check_val("t6_rst_data", out_data, 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check_val("t6_no_done", done_log.size() - b_done, 0);
        acc_en = 1'b1;
        res_tab[0] = 29'd77;
        b_pe = pe_log.size(); b_hs = hs_log.size(); b_done = done_log.size();
        launch(1, 1, s);
        wait_done(b_done, 200, "t6b_done_seen");
        check_val("t6b_pix", pe_log[b_pe], 12'h000);
        check_val("t6b_beat", hs_log[b_hs], {1'b1, 29'd77});
        check_val("t6b_err", err_timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
